// File: rtl/register_file_pkg.sv
// rtl/register_file_pkg.sv - shared widths and sizes for the rename register file
package register_file_pkg;

    // architectural register index width and count
    localparam int REG_BIT = 5;
    localparam int REG_S   = 32;

    // ROB tag width; tag 0 is reserved for "not renamed"
    localparam int ROB_BIT = 5;

    // architectural data width
    localparam int DAT_W   = 32;

endpackage

// File: rtl/rf_operand_port.sv
// rtl/rf_operand_port.sv - one operand lookup port with commit and ROB-ready bypass
module rf_operand_port
    import register_file_pkg::*;
(
    input  logic [REG_BIT-1:0] rs,
    input  logic [ROB_BIT-1:0] tag_rs,
    input  logic [DAT_W-1:0]   val_rs,
    input  logic               cmt_en,
    input  logic [REG_BIT-1:0] cmt_rd,
    input  logic [ROB_BIT-1:0] cmt_q,
    input  logic [DAT_W-1:0]   cmt_v,
    input  logic               rob_rdy,
    input  logic [DAT_W-1:0]   rob_rdyv,
    output logic [ROB_BIT-1:0] q,
    output logic [DAT_W-1:0]   v,
    output logic [ROB_BIT-1:0] rob_reqq
);

    // the ROB is always asked about whatever tag currently renames rs
    assign rob_reqq = tag_rs;

    // resolve the operand in priority order: x0, committed value, commit bypass, ROB bypass, wait on tag
    always_comb begin
        q = '0;
        v = '0;
        if (rs == '0) begin
            q = '0;
            v = '0;
        end else if (tag_rs == '0) begin
            v = val_rs;
        end else if (cmt_en && (cmt_rd == rs) && (cmt_q == tag_rs)) begin
            v = cmt_v;
        end else if (rob_rdy) begin
            v = rob_rdyv;
        end else begin
            q = tag_rs;
        end
    end

endmodule

// File: rtl/register_file.sv
// rtl/register_file.sv - architectural values plus rename tags for a Tomasulo-style core
module register_file
    import register_file_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               is_en_i,
    input  logic [REG_BIT-1:0] is_rd_i,
    input  logic [ROB_BIT-1:0] is_qd_i,
    input  logic [REG_BIT-1:0] is_rs1_i,
    input  logic [REG_BIT-1:0] is_rs2_i,
    output logic [ROB_BIT-1:0] qj_o,
    output logic [ROB_BIT-1:0] qk_o,
    output logic [DAT_W-1:0]   vj_o,
    output logic [DAT_W-1:0]   vk_o,
    output logic [ROB_BIT-1:0] rob_reqqj_o,
    output logic [ROB_BIT-1:0] rob_reqqk_o,
    input  logic               rob_rdyj_i,
    input  logic               rob_rdyk_i,
    input  logic [DAT_W-1:0]   rob_rdyvj_i,
    input  logic [DAT_W-1:0]   rob_rdyvk_i,
    input  logic               cmt_en_i,
    input  logic [REG_BIT-1:0] cmt_rd_i,
    input  logic [ROB_BIT-1:0] cmt_q_i,
    input  logic [DAT_W-1:0]   cmt_v_i,
    input  logic               br_flag_i
);

    logic [DAT_W-1:0]   val [REG_S];
    logic [ROB_BIT-1:0] tag [REG_S];

    // commit writes first so a same-cycle issue or flush overrides its tag clear; x0 is never written
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_S; i++) begin
                val[i] <= '0;
                tag[i] <= '0;
            end
        end else if (en) begin
            if (cmt_en_i && (cmt_rd_i != '0)) begin
                val[cmt_rd_i] <= cmt_v_i;
                if (tag[cmt_rd_i] == cmt_q_i) begin
                    tag[cmt_rd_i] <= '0;
                end
            end
            if (br_flag_i) begin
                for (int i = 0; i < REG_S; i++) begin
                    tag[i] <= '0;
                end
            end else if (is_en_i && (is_rd_i != '0)) begin
                tag[is_rd_i] <= is_qd_i;
            end
        end
    end

    rf_operand_port u_port_j (
        .rs       (is_rs1_i),
        .tag_rs   (tag[is_rs1_i]),
        .val_rs   (val[is_rs1_i]),
        .cmt_en   (cmt_en_i),
        .cmt_rd   (cmt_rd_i),
        .cmt_q    (cmt_q_i),
        .cmt_v    (cmt_v_i),
        .rob_rdy  (rob_rdyj_i),
        .rob_rdyv (rob_rdyvj_i),
        .q        (qj_o),
        .v        (vj_o),
        .rob_reqq (rob_reqqj_o)
    );

    rf_operand_port u_port_k (
        .rs       (is_rs2_i),
        .tag_rs   (tag[is_rs2_i]),
        .val_rs   (val[is_rs2_i]),
        .cmt_en   (cmt_en_i),
        .cmt_rd   (cmt_rd_i),
        .cmt_q    (cmt_q_i),
        .cmt_v    (cmt_v_i),
        .rob_rdy  (rob_rdyk_i),
        .rob_rdyv (rob_rdyvk_i),
        .q        (qk_o),
        .v        (vk_o),
        .rob_reqq (rob_reqqk_o)
    );

endmodule

// File: tb/tb_register_file.sv
// tb/tb_register_file.sv - randomized self-checking bench for register_file
module tb_register_file;
    import register_file_pkg::*;

    logic               clk;
    logic               rst_n;
    logic               en;
    logic               is_en_i;
    logic [REG_BIT-1:0] is_rd_i;
    logic [ROB_BIT-1:0] is_qd_i;
    logic [REG_BIT-1:0] is_rs1_i;
    logic [REG_BIT-1:0] is_rs2_i;
    logic [ROB_BIT-1:0] qj_o;
    logic [ROB_BIT-1:0] qk_o;
    logic [DAT_W-1:0]   vj_o;
    logic [DAT_W-1:0]   vk_o;
    logic [ROB_BIT-1:0] rob_reqqj_o;
    logic [ROB_BIT-1:0] rob_reqqk_o;
    logic               rob_rdyj_i;
    logic               rob_rdyk_i;
    logic [DAT_W-1:0]   rob_rdyvj_i;
    logic [DAT_W-1:0]   rob_rdyvk_i;
    logic               cmt_en_i;
    logic [REG_BIT-1:0] cmt_rd_i;
    logic [ROB_BIT-1:0] cmt_q_i;
    logic [DAT_W-1:0]   cmt_v_i;
    logic               br_flag_i;

    int n_cmp;
    int n_bad;

    // reference state: architectural value and pending renamer of each register
    logic [DAT_W-1:0]   m_val [REG_S];
    logic [ROB_BIT-1:0] m_tag [REG_S];

    register_file dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .is_en_i     (is_en_i),
        .is_rd_i     (is_rd_i),
        .is_qd_i     (is_qd_i),
        .is_rs1_i    (is_rs1_i),
        .is_rs2_i    (is_rs2_i),
        .qj_o        (qj_o),
        .qk_o        (qk_o),
        .vj_o        (vj_o),
        .vk_o        (vk_o),
        .rob_reqqj_o (rob_reqqj_o),
        .rob_reqqk_o (rob_reqqk_o),
        .rob_rdyj_i  (rob_rdyj_i),
        .rob_rdyk_i  (rob_rdyk_i),
        .rob_rdyvj_i (rob_rdyvj_i),
        .rob_rdyvk_i (rob_rdyvk_i),
        .cmt_en_i    (cmt_en_i),
        .cmt_rd_i    (cmt_rd_i),
        .cmt_q_i     (cmt_q_i),
        .cmt_v_i     (cmt_v_i),
        .br_flag_i   (br_flag_i)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [ROB_BIT-1:0] exp_q(input logic [REG_BIT-1:0] rs, input logic rdy);
        if (rs == 0 || m_tag[rs] == 0) return '0;
        if (cmt_en_i && cmt_rd_i == rs && cmt_q_i == m_tag[rs]) return '0;
        if (rdy) return '0;
        return m_tag[rs];
    endfunction

    function automatic logic [DAT_W-1:0] exp_v(input logic [REG_BIT-1:0] rs, input logic rdy,
                                               input logic [DAT_W-1:0] rdyv);
        if (rs == 0) return '0;
        if (m_tag[rs] == 0) return m_val[rs];
        if (cmt_en_i && cmt_rd_i == rs && cmt_q_i == m_tag[rs]) return cmt_v_i;
        if (rdy) return rdyv;
        return '0;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < REG_S; i++) begin
            m_val[i] = '0;
            m_tag[i] = '0;
        end
    endtask

    task automatic idle();
        en = 1'b1; is_en_i = 0; is_rd_i = 0; is_qd_i = 0; is_rs1_i = 0; is_rs2_i = 0;
        rob_rdyj_i = 0; rob_rdyk_i = 0; rob_rdyvj_i = 0; rob_rdyvk_i = 0;
        cmt_en_i = 0; cmt_rd_i = 0; cmt_q_i = 0; cmt_v_i = 0; br_flag_i = 0;
    endtask

    // one rising edge; the model applies the architectural rules to the inputs held across it
    task automatic step();
        @(posedge clk);
        if (en) begin
            if (cmt_en_i && cmt_rd_i != 0) begin
                if (m_tag[cmt_rd_i] == cmt_q_i) m_tag[cmt_rd_i] = '0;
                m_val[cmt_rd_i] = cmt_v_i;
            end
            if (br_flag_i) begin
                for (int i = 0; i < REG_S; i++) m_tag[i] = '0;
            end else if (is_en_i && is_rd_i != 0) begin
                m_tag[is_rd_i] = is_qd_i;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        model_clear();
        is_rs1_i = 5'd5; is_rs2_i = 5'd0;
        repeat (2) @(negedge clk);
        #1;
        n_cmp++; if (qj_o !== 0 || vj_o !== 0) begin n_bad++; $display("FAIL reset_j: q=%0d v=%h want 0/0", qj_o, vj_o); end
        n_cmp++; if (qk_o !== 0 || vk_o !== 0) begin n_bad++; $display("FAIL reset_k: q=%0d v=%h want 0/0", qk_o, vk_o); end
        n_cmp++; if (rob_reqqj_o !== 0 || rob_reqqk_o !== 0) begin n_bad++; $display("FAIL reset_req: %0d %0d want 0 0", rob_reqqj_o, rob_reqqk_o); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_cmp++; if (qj_o !== 0 || vj_o !== 0) begin n_bad++; $display("FAIL after_reset_j: q=%0d v=%h want 0/0", qj_o, vj_o); end
        @(negedge clk);
    endtask

    task automatic test_issue_rob_bypass();
        idle();
        is_en_i = 1; is_rd_i = 5'd3; is_qd_i = 5'd7; is_rs1_i = 5'd3;
        #1;
        n_cmp++; if (qj_o !== 0) begin n_bad++; $display("FAIL own_tag_hidden: q=%0d want 0", qj_o); end
        step();
        idle();
        is_rs1_i = 5'd3;
        #1;
        n_cmp++; if (qj_o !== 5'd7 || vj_o !== 0) begin n_bad++; $display("FAIL renamed_read: q=%0d v=%h want 7/0", qj_o, vj_o); end
        n_cmp++; if (rob_reqqj_o !== 5'd7) begin n_bad++; $display("FAIL rob_query: %0d want 7", rob_reqqj_o); end
        rob_rdyj_i = 1; rob_rdyvj_i = 32'h55;
        #1;
        n_cmp++; if (qj_o !== 0 || vj_o !== 32'h55) begin n_bad++; $display("FAIL rob_bypass: q=%0d v=%h want 0/55", qj_o, vj_o); end
    endtask

    task automatic test_commit_bypass();
        idle();
        cmt_en_i = 1; cmt_rd_i = 5'd3; cmt_q_i = 5'd7; cmt_v_i = 32'hAB; is_rs1_i = 5'd3;
        #1;
        n_cmp++; if (qj_o !== 0 || vj_o !== 32'hAB) begin n_bad++; $display("FAIL commit_bypass: q=%0d v=%h want 0/ab", qj_o, vj_o); end
        step();
        idle();
        is_rs1_i = 5'd3;
        #1;
        n_cmp++; if (qj_o !== 0 || vj_o !== 32'hAB) begin n_bad++; $display("FAIL commit_write: q=%0d v=%h want 0/ab", qj_o, vj_o); end
    endtask

    task automatic test_issue_commit_same();
        idle();
        is_en_i = 1; is_rd_i = 5'd3; is_qd_i = 5'd7;
        step();
        idle();
        is_en_i = 1; is_rd_i = 5'd3; is_qd_i = 5'd9;
        cmt_en_i = 1; cmt_rd_i = 5'd3; cmt_q_i = 5'd7; cmt_v_i = 32'd1;
        step();
        idle();
        is_rs1_i = 5'd3;
        #1;
        n_cmp++; if (qj_o !== 5'd9 || vj_o !== 0) begin n_bad++; $display("FAIL issue_beats_clear: q=%0d v=%h want 9/0", qj_o, vj_o); end
        br_flag_i = 1;
        step();
        idle();
        is_rs1_i = 5'd3;
        #1;
        n_cmp++; if (qj_o !== 0 || vj_o !== 32'd1) begin n_bad++; $display("FAIL younger_val: q=%0d v=%h want 0/1", qj_o, vj_o); end
    endtask

    task automatic test_flush();
        idle();
        is_en_i = 1; is_rd_i = 5'd1; is_qd_i = 5'd2;
        step();
        is_rd_i = 5'd2; is_qd_i = 5'd4;
        step();
        idle();
        br_flag_i = 1; is_en_i = 1; is_rd_i = 5'd5; is_qd_i = 5'd6;
        cmt_en_i = 1; cmt_rd_i = 5'd1; cmt_q_i = 5'd2; cmt_v_i = 32'h10;
        step();
        idle();
        is_rs1_i = 5'd1; is_rs2_i = 5'd2;
        #1;
        n_cmp++; if (qj_o !== 0 || vj_o !== 32'h10) begin n_bad++; $display("FAIL flush_commit: q=%0d v=%h want 0/10", qj_o, vj_o); end
        n_cmp++; if (qk_o !== 0 || vk_o !== m_val[2]) begin n_bad++; $display("FAIL flush_x2: q=%0d v=%h want 0/%h", qk_o, vk_o, m_val[2]); end
        is_rs1_i = 5'd5;
        #1;
        n_cmp++; if (qj_o !== 0 || rob_reqqj_o !== 0) begin n_bad++; $display("FAIL flush_drops_issue: q=%0d req=%0d want 0/0", qj_o, rob_reqqj_o); end
    endtask

    task automatic test_x0_and_async_reset();
        idle();
        is_en_i = 1; is_rd_i = 0; is_qd_i = 5'd5;
        cmt_en_i = 1; cmt_rd_i = 0; cmt_q_i = 0; cmt_v_i = 32'hFF;
        step();
        idle();
        is_rs1_i = 0;
        #1;
        n_cmp++; if (qj_o !== 0 || vj_o !== 0 || rob_reqqj_o !== 0) begin n_bad++; $display("FAIL x0_read: q=%0d v=%h req=%0d want 0/0/0", qj_o, vj_o, rob_reqqj_o); end
        is_en_i = 1; is_rd_i = 5'd4; is_qd_i = 5'd3;
        cmt_en_i = 1; cmt_rd_i = 5'd6; cmt_q_i = 5'd1; cmt_v_i = 32'h1234;
        step();
        idle();
        is_rs1_i = 5'd4; is_rs2_i = 5'd6;
        #1;
        n_cmp++; if (qj_o !== 5'd3 || vk_o !== 32'h1234) begin n_bad++; $display("FAIL pre_reset_state: q=%0d v=%h want 3/1234", qj_o, vk_o); end
        #1 rst_n = 1'b0;
        #1;
        n_cmp++; if (qj_o !== 0 || rob_reqqj_o !== 0 || vk_o !== 0) begin n_bad++; $display("FAIL async_reset: q=%0d req=%0d v=%h want 0/0/0", qj_o, rob_reqqj_o, vk_o); end
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_enable_freeze();
        idle();
        is_en_i = 1; is_rd_i = 5'd8; is_qd_i = 5'd11;
        step();
        idle();
        en = 0; is_en_i = 1; is_rd_i = 5'd9; is_qd_i = 5'd12;
        cmt_en_i = 1; cmt_rd_i = 5'd8; cmt_q_i = 5'd11; cmt_v_i = 32'hDEAD; br_flag_i = 1;
        step();
        idle();
        is_rs1_i = 5'd8; is_rs2_i = 5'd9;
        #1;
        n_cmp++; if (qj_o !== 5'd11) begin n_bad++; $display("FAIL freeze_tag8: q=%0d want 11", qj_o); end
        n_cmp++; if (qk_o !== 0 || vk_o !== m_val[9]) begin n_bad++; $display("FAIL freeze_x9: q=%0d v=%h want 0/%h", qk_o, vk_o, m_val[9]); end
    endtask

    task automatic test_random();
        logic [ROB_BIT-1:0] eq;
        logic [DAT_W-1:0]   ev;
        for (int n = 0; n < 400; n++) begin
            en          = ($urandom_range(9) != 0);
            is_en_i     = $urandom_range(1);
            is_rd_i     = REG_BIT'($urandom_range(REG_S - 1));
            is_qd_i     = ROB_BIT'($urandom_range(31, 1));
            is_rs1_i    = REG_BIT'($urandom_range(7));
            is_rs2_i    = REG_BIT'($urandom_range(7));
            rob_rdyj_i  = ($urandom_range(3) == 0);
            rob_rdyk_i  = ($urandom_range(3) == 0);
            rob_rdyvj_i = $urandom;
            rob_rdyvk_i = $urandom;
            cmt_en_i    = $urandom_range(1);
            cmt_rd_i    = REG_BIT'($urandom_range(7));
            cmt_q_i     = $urandom_range(1) ? m_tag[cmt_rd_i] : ROB_BIT'($urandom_range(31));
            cmt_v_i     = $urandom;
            br_flag_i   = ($urandom_range(15) == 0);
            if (is_en_i && $urandom_range(1)) is_rd_i = REG_BIT'($urandom_range(7));
            #1;
            eq = exp_q(is_rs1_i, rob_rdyj_i);
            ev = exp_v(is_rs1_i, rob_rdyj_i, rob_rdyvj_i);
            n_cmp++; if (qj_o !== eq || vj_o !== ev) begin n_bad++; $display("FAIL rand_j[%0d]: q=%0d v=%h want %0d/%h", n, qj_o, vj_o, eq, ev); end
            eq = exp_q(is_rs2_i, rob_rdyk_i);
            ev = exp_v(is_rs2_i, rob_rdyk_i, rob_rdyvk_i);
            n_cmp++; if (qk_o !== eq || vk_o !== ev) begin n_bad++; $display("FAIL rand_k[%0d]: q=%0d v=%h want %0d/%h", n, qk_o, vk_o, eq, ev); end
            n_cmp++; if (rob_reqqj_o !== m_tag[is_rs1_i] || rob_reqqk_o !== m_tag[is_rs2_i]) begin
                n_bad++; $display("FAIL rand_req[%0d]: %0d %0d want %0d %0d", n, rob_reqqj_o, rob_reqqk_o, m_tag[is_rs1_i], m_tag[is_rs2_i]);
            end
            step();
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_issue_rob_bypass();
        test_commit_bypass();
        test_issue_commit_same();
        test_flush();
        test_x0_and_async_reset();
        test_enable_freeze();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-003 en  input  1  global enable; 0 freezes all state, reads stay live.
REQ-004 is_en_i  input  1  issue valid; rename rd to is_qd_i.
REQ-005 is_rd_i  input  REG_BIT  issued instruction destination register.
REQ-006 is_qd_i  input  ROB_BIT  ROB tag allocated to issued instruction (ROB tail).
REQ-007 is_rs1_i / is_rs2_i  input  REG_BIT  source operand register indices.
REQ-008 qj_o / qk_o  output  ROB_BIT  operand dependency tag; 0 = value valid.
REQ-009 vj_o / vk_o  output  DAT_W  operand value; 0 when q nonzero.
REQ-010 rob_reqqj_o / rob_reqqk_o  output  ROB_BIT  tag query to ROB ready lookup.
REQ-011 rob_rdyj_i / rob_rdyk_i  input  1  queried ROB entry finished.
REQ-012 rob_rdyvj_i / rob_rdyvk_i  input  DAT_W  queried ROB entry value.
REQ-013 cmt_en_i  input  1  ROB commit write valid.
REQ-014 cmt_rd_i  input  REG_BIT  committed destination register.
REQ-015 cmt_q_i  input  ROB_BIT  committed ROB tag.
REQ-016 cmt_v_i  input  DAT_W  committed value.
REQ-017 br_flag_i  input  1  misprediction flush from ROB.

Function
REQ-018 State: REG_S x DAT_W values val[], REG_S x ROB_BIT tags tag[]; tag 0 means "not renamed" (ROB tags start at 1).
REQ-019 Register x0 reads value 0, tag 0 always; writes and renames to x0 are ignored.
REQ-020 Operand lookup is combinational, zero latency, per port (j uses rs1, k uses rs2), priority order below.
REQ-021 rs==0 -> q=0, v=0.
REQ-022 tag[rs]==0 -> q=0, v=val[rs].
REQ-023 cmt_en_i && cmt_rd_i==rs && cmt_q_i==tag[rs] -> q=0, v=cmt_v_i (commit bypass).
REQ-024 rob_rdy*_i -> q=0, v=rob_rdyv*_i (ROB-ready bypass); rob_reqq*_o = tag[rs] always.
REQ-025 Otherwise q=tag[rs], v=0.
REQ-026 Lookup reflects state before same-cycle issue: an instruction with rs==rd never sees its own tag.
REQ-027 Commit (en, cmt_en_i, cmt_rd_i!=0): val[cmt_rd_i] <= cmt_v_i next edge.
REQ-028 Commit clears tag[cmt_rd_i] to 0 only if tag[cmt_rd_i]==cmt_q_i (no younger renamer).
REQ-029 Issue (en, is_en_i, is_rd_i!=0): tag[is_rd_i] <= is_qd_i; wins over a same-cycle commit tag clear on the same register.
REQ-030 Flush (en, br_flag_i): all tags <= 0; same-cycle issue rename discarded; same-cycle commit value write still performed.
REQ-031 en=0: no val/tag change regardless of is_en_i, cmt_en_i, br_flag_i.

Reset
REQ-032 rst_n low: all val[] and tag[] <= 0 immediately, independent of clk; held while low.
REQ-033 Outputs during/after reset: qj_o=qk_o=0, vj_o=vk_o=0 for any index, rob_reqq*_o=0.
REQ-034 First update on first rising edge after rst_n deasserts.

Structure
REQ-035 REG_BIT(5), REG_S(32), ROB_BIT(5), DAT_W(32) come from the shared head definitions; none redefined locally.
REQ-036 One sub-module rf_operand_port implementing REQ-021..025, instantiated twice (j, k).

Verification
REQ-037 Reset, read rs1=5 rs2=0 -> qj=0 vj=0, qk=0 vk=0.
REQ-038 Issue rd=3 qd=7; next cycle read rs1=3, rob_rdyj=0 -> qj=7 vj=0; rob_rdyj=1 rdyvj=0x55 -> qj=0 vj=0x55.
REQ-039 tag[3]=7; commit rd=3 q=7 v=0xAB with read rs1=3 same cycle -> qj=0 vj=0xAB; next cycle tag[3]=0 val[3]=0xAB.
REQ-040 tag[3]=7; issue rd=3 qd=9 and commit rd=3 q=7 v=1 same cycle -> val[3]=1, tag[3]=9; read gives qj=9.
REQ-041 tags x1=2, x2=4; br_flag with issue rd=5 qd=6 and commit rd=1 q=2 v=0x10 -> all tags 0, val[1]=0x10, x5 unrenamed.
REQ-042 Issue/commit to x0 with v=0xFF, then read rs1=0 -> qj=0 vj=0; rst_n pulsed low mid-run between edges -> tags/values 0 before next edge.
